// File: rtl/exec_pkg.sv
// Shared function codes, default widths and state/unit encodings for the
// execution stage that feeds the common data bus.
package exec_pkg;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ROB_W  = 3;
    localparam int unsigned DEF_RD_W   = 4;
    localparam int unsigned DEF_RSI_W  = 2;

    typedef enum logic [1:0] {AddIdle, AddBusy, AddDone} add_state_e;
    typedef enum logic [1:0] {MulIdle, MulBusy, DivBusy, MulDone} mul_state_e;
    typedef enum logic {UnitAdd = 1'b0, UnitMul = 1'b1} cdb_unit_e;

    // Everything that is not mul/div (including illegal codes) goes to the add unit.
    function automatic logic is_mul_func(input logic [3:0] func);
        return (func == FUNC_MUL) || (func == FUNC_DIV);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, DATA_W cycles per divide.
// A zero divisor naturally yields an all-ones quotient.
module div_iter #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dsr_q;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   diff;
    logic              ge;

    // quo_q shifts dividend bits out of the top and quotient bits in at the bottom.
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign diff      = rem_shift - {1'b0, dsr_q};
    assign ge        = rem_shift >= {1'b0, dsr_q};
    assign busy      = cnt_q != '0;
    // High during the cycle whose closing edge writes the final quotient bit.
    assign done      = cnt_q == CNT_W'(1);
    assign quotient  = quo_q;

    always_ff @(posedge clk1) begin
        if (!rst_n || flush) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (start) begin
            cnt_q <= CNT_W'(DATA_W);
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (busy) begin
            cnt_q <= cnt_q - CNT_W'(1);
            rem_q <= ge ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], ge};
        end
    end

endmodule

// File: rtl/fu_exec_cdb.sv
// Add/sub and mul/div execution units with a registered, mul-priority CDB.
// Define FU_DIV_EN to build the iterative divider; otherwise func 0011 is illegal.
module fu_exec_cdb
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ROB_W   = DEF_ROB_W,
    parameter int unsigned RD_W    = DEF_RD_W,
    parameter int unsigned RSI_W   = DEF_RSI_W,
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [3:0]        disp_func,
    input  logic [DATA_W-1:0] disp_rs1data,
    input  logic [DATA_W-1:0] disp_rs2data,
    input  logic [ROB_W-1:0]  disp_rob_ind,
    input  logic [RD_W-1:0]   disp_rd,
    input  logic [RSI_W-1:0]  disp_rsindex,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_data,
    output logic [ROB_W-1:0]  cdb_rob_ind,
    output logic [RD_W-1:0]   cdb_rd,
    output logic [RSI_W-1:0]  cdb_rsindex,
    output logic              cdb_unit,
    output logic              cdb_exc
);

    localparam int unsigned ACNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam int unsigned MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    add_state_e        add_state_q;
    logic [ACNT_W-1:0] add_cnt_q;
    logic [3:0]        add_func_q;
    logic [DATA_W-1:0] add_a_q, add_b_q;
    logic [ROB_W-1:0]  add_rob_q;
    logic [RD_W-1:0]   add_rd_q;
    logic [RSI_W-1:0]  add_rsi_q;

    mul_state_e        mul_state_q;
    logic [MCNT_W-1:0] mul_cnt_q;
    logic              mul_exc_q;
    logic              mul_div_q;
    logic [DATA_W-1:0] mul_a_q, mul_b_q;
    logic [ROB_W-1:0]  mul_rob_q;
    logic [RD_W-1:0]   mul_rd_q;
    logic [RSI_W-1:0]  mul_rsi_q;

    logic              to_mul, accept, add_accept, mul_accept;
    logic              add_grant, mul_grant;
    logic [DATA_W-1:0] add_res, mul_res, mul_prod;
    logic              add_exc;
    logic [DATA_W-1:0] div_quo;
    logic              div_done, div_busy;

    assign to_mul     = is_mul_func(disp_func);
    assign disp_ready = to_mul ? (mul_state_q == MulIdle) : (add_state_q == AddIdle);
    assign accept     = disp_valid && disp_ready && !flush;
    assign add_accept = accept && !to_mul;
    assign mul_accept = accept && to_mul;

    // Mul unit always wins a tie; add holds in DONE for another cycle.
    assign mul_grant = mul_state_q == MulDone;
    assign add_grant = (add_state_q == AddDone) && !mul_grant;

`ifdef FU_DIV_EN
    logic div_start;
    assign div_start = mul_accept && (disp_func == FUNC_DIV);

    div_iter #(
        .DATA_W(DATA_W)
    ) u_div_iter (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .flush   (flush),
        .start   (div_start),
        .dividend(disp_rs1data),
        .divisor (disp_rs2data),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_quo)
    );
`else
    assign div_quo  = '0;
    assign div_done = 1'b0;
    assign div_busy = 1'b0;
`endif

    always_comb begin
        add_res = '0;
        add_exc = 1'b0;
        case (add_func_q)
            FUNC_ADD: add_res = add_a_q + add_b_q;
            FUNC_SUB: add_res = add_a_q - add_b_q;
            default:  add_exc = 1'b1;
        endcase
    end

    assign mul_prod = mul_a_q * mul_b_q;

    always_comb begin
        if (mul_exc_q) begin
            mul_res = '0;
        end else if (mul_div_q) begin
            mul_res = div_quo;
        end else begin
            mul_res = mul_prod;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n || flush) begin
            add_state_q <= AddIdle;
            add_cnt_q   <= '0;
            add_func_q  <= FUNC_ADD;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_rob_q   <= '0;
            add_rd_q    <= '0;
            add_rsi_q   <= '0;
        end else begin
            unique case (add_state_q)
                AddIdle: begin
                    if (add_accept) begin
                        add_state_q <= AddBusy;
                        add_cnt_q   <= ACNT_W'(ADD_LAT - 1);
                        add_func_q  <= disp_func;
                        add_a_q     <= disp_rs1data;
                        add_b_q     <= disp_rs2data;
                        add_rob_q   <= disp_rob_ind;
                        add_rd_q    <= disp_rd;
                        add_rsi_q   <= disp_rsindex;
                    end
                end
                AddBusy: begin
                    if (add_cnt_q == '0) begin
                        add_state_q <= AddDone;
                    end else begin
                        add_cnt_q <= add_cnt_q - ACNT_W'(1);
                    end
                end
                AddDone: begin
                    if (add_grant) begin
                        add_state_q <= AddIdle;
                    end
                end
                default: add_state_q <= AddIdle;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n || flush) begin
            mul_state_q <= MulIdle;
            mul_cnt_q   <= '0;
            mul_exc_q   <= 1'b0;
            mul_div_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_rob_q   <= '0;
            mul_rd_q    <= '0;
            mul_rsi_q   <= '0;
        end else begin
            unique case (mul_state_q)
                MulIdle: begin
                    if (mul_accept) begin
                        mul_cnt_q <= MCNT_W'(MUL_LAT - 1);
                        mul_a_q   <= disp_rs1data;
                        mul_b_q   <= disp_rs2data;
                        mul_rob_q <= disp_rob_ind;
                        mul_rd_q  <= disp_rd;
                        mul_rsi_q <= disp_rsindex;
`ifdef FU_DIV_EN
                        mul_exc_q   <= 1'b0;
                        mul_div_q   <= disp_func == FUNC_DIV;
                        mul_state_q <= (disp_func == FUNC_DIV) ? DivBusy : MulBusy;
`else
                        mul_exc_q   <= disp_func == FUNC_DIV;
                        mul_div_q   <= 1'b0;
                        mul_state_q <= MulBusy;
`endif
                    end
                end
                MulBusy: begin
                    if (mul_cnt_q == '0) begin
                        mul_state_q <= MulDone;
                    end else begin
                        mul_cnt_q <= mul_cnt_q - MCNT_W'(1);
                    end
                end
                DivBusy: begin
                    if (div_done) begin
                        mul_state_q <= MulDone;
                    end else if (!div_busy) begin
                        mul_state_q <= MulIdle;
                    end
                end
                MulDone: begin
                    if (mul_grant) begin
                        mul_state_q <= MulIdle;
                    end
                end
                default: mul_state_q <= MulIdle;
            endcase
        end
    end

    // Fields hold their last broadcast while cdb_valid is low.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            cdb_valid   <= 1'b0;
            cdb_data    <= '0;
            cdb_rob_ind <= '0;
            cdb_rd      <= '0;
            cdb_rsindex <= '0;
            cdb_unit    <= 1'b0;
            cdb_exc     <= 1'b0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (mul_grant) begin
            cdb_valid   <= 1'b1;
            cdb_data    <= mul_res;
            cdb_rob_ind <= mul_rob_q;
            cdb_rd      <= mul_rd_q;
            cdb_rsindex <= mul_rsi_q;
            cdb_unit    <= UnitMul;
            cdb_exc     <= mul_exc_q;
        end else if (add_grant) begin
            cdb_valid   <= 1'b1;
            cdb_data    <= add_res;
            cdb_rob_ind <= add_rob_q;
            cdb_rd      <= add_rd_q;
            cdb_rsindex <= add_rsi_q;
            cdb_unit    <= UnitAdd;
            cdb_exc     <= add_exc;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fu_exec_cdb.sv
// Bench for fu_exec_cdb: directed cases plus random traffic against a
// transaction-level model (per-unit occupancy, ready edge, mul-first CDB).
module tb_fu_exec_cdb;
    import exec_pkg::*;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ROB_W   = 3;
    localparam int unsigned RD_W    = 4;
    localparam int unsigned RSI_W   = 2;
    localparam int unsigned ADD_LAT = 1;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned META_W  = ROB_W + RD_W + RSI_W + 2;
`ifdef FU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic              clk1 = 1'b0;
    logic              rst_n, flush, disp_valid, disp_ready;
    logic [3:0]        disp_func;
    logic [DATA_W-1:0] disp_rs1data, disp_rs2data;
    logic [ROB_W-1:0]  disp_rob_ind;
    logic [RD_W-1:0]   disp_rd;
    logic [RSI_W-1:0]  disp_rsindex;
    logic              cdb_valid, cdb_unit, cdb_exc;
    logic [DATA_W-1:0] cdb_data;
    logic [ROB_W-1:0]  cdb_rob_ind;
    logic [RD_W-1:0]   cdb_rd;
    logic [RSI_W-1:0]  cdb_rsindex;
    logic [META_W-1:0] cdb_meta;

    assign cdb_meta = {cdb_rob_ind, cdb_rd, cdb_rsindex, cdb_unit, cdb_exc};

    fu_exec_cdb #(
        .DATA_W (DATA_W),
        .ROB_W  (ROB_W),
        .RD_W   (RD_W),
        .RSI_W  (RSI_W),
        .ADD_LAT(ADD_LAT),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_func   (disp_func),
        .disp_rs1data(disp_rs1data),
        .disp_rs2data(disp_rs2data),
        .disp_rob_ind(disp_rob_ind),
        .disp_rd     (disp_rd),
        .disp_rsindex(disp_rsindex),
        .cdb_valid   (cdb_valid),
        .cdb_data    (cdb_data),
        .cdb_rob_ind (cdb_rob_ind),
        .cdb_rd      (cdb_rd),
        .cdb_rsindex (cdb_rsindex),
        .cdb_unit    (cdb_unit),
        .cdb_exc     (cdb_exc)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Model: unit 0 = add, unit 1 = mul; m_rdy is the first edge it may broadcast on.
    bit [1:0]          m_busy;
    int                m_rdy[2];
    logic [DATA_W-1:0] m_data[2];
    logic [META_W-1:0] m_meta[2];
    bit                e_valid;
    logic [DATA_W-1:0] e_data;
    logic [META_W-1:0] e_meta;
    int                edge_n  = 0;
    bit                started = 1'b0;

    function automatic void ref_exec(input logic [3:0] f, input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b, output logic [DATA_W-1:0] r,
                                     output bit exc, output int lat);
        longint unsigned p;
        exc = 1'b0;
        r   = '0;
        lat = ADD_LAT;
        case (f)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: begin
                p   = longint'(a) * longint'(b);
                r   = p[DATA_W-1:0];
                lat = MUL_LAT;
            end
            4'd3: begin
                lat = DIV_ON ? DATA_W : MUL_LAT;
                exc = !DIV_ON;
                if (DIV_ON) r = (b == 0) ? {DATA_W{1'b1}} : a / b;
            end
            default: exc = 1'b1;
        endcase
    endfunction

    task automatic step();
        bit                tgt, acc, exc;
        int                win, lat;
        logic [DATA_W-1:0] r;
        #1;
        tgt = (disp_func == FUNC_MUL) || (disp_func == FUNC_DIV);
        if (started) check("disp_ready", disp_ready, !m_busy[tgt]);
        acc = rst_n && !flush && disp_valid && !m_busy[tgt];
        @(posedge clk1);
        edge_n++;
        if (!rst_n) begin
            m_busy  = '0;
            e_valid = 1'b0;
            e_data  = '0;
            e_meta  = '0;
            started = 1'b1;
        end else if (flush) begin
            m_busy  = '0;
            e_valid = 1'b0;
        end else begin
            win = -1;
            if (m_busy[1] && m_rdy[1] <= edge_n) win = 1;
            else if (m_busy[0] && m_rdy[0] <= edge_n) win = 0;
            e_valid = win >= 0;
            if (win >= 0) begin
                e_data      = m_data[win];
                e_meta      = m_meta[win];
                m_busy[win] = 1'b0;
            end
            if (acc) begin
                ref_exec(disp_func, disp_rs1data, disp_rs2data, r, exc, lat);
                m_busy[tgt] = 1'b1;
                m_rdy[tgt]  = edge_n + lat + 1;
                m_data[tgt] = r;
                m_meta[tgt] = {disp_rob_ind, disp_rd, disp_rsindex, tgt, exc};
            end
        end
        #1;
        if (started) begin
            check("cdb_valid", cdb_valid, e_valid);
            check("cdb_data", cdb_data, e_data);
            check("cdb_meta", cdb_meta, e_meta);
        end
    endtask

    task automatic issue(input logic [3:0] f, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [ROB_W-1:0] rob,
                         input logic [RD_W-1:0] rd, input logic [RSI_W-1:0] rsi);
        disp_func    = f;
        disp_rs1data = a;
        disp_rs2data = b;
        disp_rob_ind = rob;
        disp_rd      = rd;
        disp_rsindex = rsi;
        disp_valid   = 1'b1;
        step();
        disp_valid = 1'b0;
    endtask

    // Edges after the issue edge until cdb_valid is seen; -1 if the bound expires.
    task automatic wait_pulse(input int limit, output int edges);
        edges = -1;
        for (int k = 1; k <= limit && edges < 0; k++) begin
            step();
            if (cdb_valid === 1'b1) edges = k;
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (cdb_valid === 1'b1) pulses++;
        end
    endtask

    initial begin
        int lat, pulses;
        rst_n        = 1'b0;
        flush        = 1'b0;
        disp_valid   = 1'b0;
        disp_func    = FUNC_ADD;
        disp_rs1data = '0;
        disp_rs2data = '0;
        disp_rob_ind = '0;
        disp_rd      = '0;
        disp_rsindex = '0;
        step();
        step();
        check("reset_cdb", {cdb_valid, cdb_data, cdb_meta}, '0);
        rst_n = 1'b1;
        #1 check("reset_ready", disp_ready, 1'b1);

        issue(FUNC_ADD, 16'h0005, 16'h0003, 3'd2, 4'd4, 2'd1);
        wait_pulse(10, lat);
        check("add_latency", lat, ADD_LAT + 1);
        check("add_data", cdb_data, 16'h0008);
        check("add_tags", cdb_meta, {3'd2, 4'd4, 2'd1, 1'b0, 1'b0});
        step();
        check("add_single_pulse", cdb_valid, 1'b0);

        issue(FUNC_SUB, 16'h0000, 16'h0001, 3'd3, 4'd5, 2'd2);
        wait_pulse(10, lat);
        check("sub_data", {cdb_data, cdb_exc}, {16'hFFFF, 1'b0});

        issue(FUNC_MUL, 16'h0100, 16'h0100, 3'd4, 4'd6, 2'd3);
        disp_func = FUNC_MUL;
        #1 check("mul_busy_ready", disp_ready, 1'b0);
        wait_pulse(10, lat);
        check("mul_latency", lat, MUL_LAT + 1);
        check("mul_data", {cdb_data, cdb_unit}, {16'h0000, 1'b1});

        // Add issued two edges after mul so both reach DONE together.
        issue(FUNC_MUL, 16'd3, 16'd5, 3'd5, 4'd1, 2'd0);
        step();
        issue(FUNC_ADD, 16'd7, 16'd9, 3'd6, 4'd2, 2'd1);
        step();
        check("both_none_yet", cdb_valid, 1'b0);
        step();
        check("both_mul_first", {cdb_valid, cdb_unit, cdb_data}, {1'b1, 1'b1, 16'd15});
        step();
        check("both_add_next", {cdb_valid, cdb_unit, cdb_data}, {1'b1, 1'b0, 16'd16});
        step();
        check("both_drained", cdb_valid, 1'b0);

        issue(FUNC_DIV, 16'h0064, 16'h0007, 3'd1, 4'd3, 2'd2);
        wait_pulse(40, lat);
        check("div_latency", lat, DIV_ON ? DATA_W + 1 : MUL_LAT + 1);
        check("div_data", {cdb_data, cdb_exc}, DIV_ON ? {16'h000E, 1'b0} : {16'h0000, 1'b1});
        issue(FUNC_DIV, 16'h1234, 16'h0000, 3'd2, 4'd7, 2'd3);
        wait_pulse(40, lat);
        check("div0_data", {cdb_data, cdb_exc}, DIV_ON ? {16'hFFFF, 1'b0} : {16'h0000, 1'b1});

        issue(4'b0101, 16'h0009, 16'h0009, 3'd7, 4'd8, 2'd0);
        wait_pulse(10, lat);
        check("illegal_latency", lat, ADD_LAT + 1);
        check("illegal_result", {cdb_data, cdb_unit, cdb_exc}, {16'h0000, 1'b0, 1'b1});

        // Flush while mul is busy; the add presented alongside it is dropped.
        issue(FUNC_MUL, 16'd2, 16'd3, 3'd0, 4'd9, 2'd1);
        step();
        flush      = 1'b1;
        disp_valid = 1'b1;
        disp_func  = FUNC_ADD;
        step();
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_func  = FUNC_MUL;
        #1 check("flush_ready", disp_ready, 1'b1);
        count_pulses(8, pulses);
        check("flush_no_pulse", pulses, 0);

        issue(FUNC_DIV, 16'hFFFF, 16'h0003, 3'd3, 4'd10, 2'd2);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        check("rst_mid_cdb", {cdb_valid, cdb_data, cdb_meta}, '0);
        rst_n     = 1'b1;
        disp_func = FUNC_DIV;
        #1 check("rst_mid_ready", disp_ready, 1'b1);
        count_pulses(25, pulses);
        check("rst_mid_no_pulse", pulses, 0);

        repeat (1500) begin
            rst_n      = $urandom_range(0, 199) != 0;
            flush      = $urandom_range(0, 39) == 0;
            disp_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       disp_func = FUNC_ADD;
                1:       disp_func = FUNC_SUB;
                2:       disp_func = FUNC_MUL;
                3:       disp_func = FUNC_DIV;
                default: disp_func = 4'($urandom_range(4, 15));
            endcase
            disp_rs1data = DATA_W'($urandom);
            disp_rs2data = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
            disp_rob_ind = ROB_W'($urandom);
            disp_rd      = RD_W'($urandom);
            disp_rsindex = RSI_W'($urandom);
            step();
        end
        rst_n      = 1'b1;
        flush      = 1'b0;
        disp_valid = 1'b0;
        repeat (30) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
